// File: rtl/d_ff_input_conditioner.sv
// Input conditioner for the advanced D flip-flop: synchronises and debounces a raw
// pin, producing a clean D level plus a one-cycle enable strobe. Define D_FF_COND_EDGE_EN for rise/fall strobes.
module d_ff_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_WIDTH       = 8
) (
    input  logic clk,
    input  logic reset_sync_n,
    input  logic din,
    input  logic hold,
    output logic D,
    output logic enable,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        IDLE,
        QUALIFY
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic                   d_next;
    logic                   commit;

    // Not frozen by hold, so the sampled level is current the moment hold drops.
    always_ff @(posedge clk) begin
        if (!reset_sync_n) sync_q <= '0;
        else               sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_sync_n) begin
            state  <= IDLE;
            cnt    <= '0;
            D      <= 1'b0;
            enable <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            D      <= d_next;
            enable <= commit;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        d_next     = D;
        commit     = 1'b0;
        if (hold || (s == D)) begin
            // A bounce back to the held level throws away partial qualification.
            state_next = IDLE;
            cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
            d_next     = ~D;
            commit     = 1'b1;
        end else begin
            state_next = QUALIFY;
            cnt_next   = cnt + 1'b1;
        end
    end

    assign busy = (state == QUALIFY);

`ifdef D_FF_COND_EDGE_EN
    always_ff @(posedge clk) begin
        if (!reset_sync_n) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= commit & d_next;
            fall <= commit & ~d_next;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule
